fdiv_iter: RTL

- Iterative single-precision divider, y = x1 / x2: the inverse operation to the pipelined multiplier in the same FPU.
- Uses radix-2 restoring division on the 24-bit significands, producing one quotient bit per cycle.
- Valid/ready handshakes on both sides; at most one operation in flight.
- Number format matches the multiplier: zero-exponent inputs count as zero, results flush to zero, no subnormals.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fdiv_round.sv | 56 +++++
 rtl/fdiv_iter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: field widths, exponent bias, divider iteration
// count, divider state encoding and the infinity magnitude pattern.
package fpu_pkg;

    localparam int EXP_W      = 8;
    localparam int MAN_W      = 23;
    localparam int BIAS       = 127;

    // One quotient bit per iteration: integer bit, 23 fraction bits,
    // the hidden-bit position when the quotient is < 1, and a round bit.
    localparam int FDIV_ITERS = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fdiv_state_t;

    localparam logic [30:0] FP_INF_MAG = 31'h7F800000;

endpackage

// File: rtl/fdiv_round.sv
// Quotient post-processing for the iterative divider: normalizes the raw
// 26-bit quotient, rounds to nearest (ties away from zero) and applies
// the zero / infinity / flush-to-zero exception mux. Purely combinational.
module fdiv_round #(
    parameter int BIAS = 127
) (
    input  logic [25:0]                q,
    input  logic                       s,
    input  logic [fpu_pkg::EXP_W-1:0]  e1,
    input  logic [fpu_pkg::EXP_W-1:0]  e2,
    output logic [31:0]                y
);
    import fpu_pkg::*;

    localparam logic [9:0] BIAS_W = 10'(BIAS);

    logic [MAN_W-1:0]  frac;
    logic              rb;
    logic signed [9:0] e_norm;
    logic [MAN_W:0]    frac_rnd;
    logic signed [9:0] e_rnd;

    // Normalize: the quotient lies in [0.5, 2), so at most one position of
    // adjustment. The hidden bit is implied and only the fraction is kept.
    always_comb begin
        if (q[25]) begin
            frac   = q[24:2];
            rb     = q[1];
            e_norm = {2'b00, e1} - {2'b00, e2} + BIAS_W;
        end else begin
            frac   = q[23:1];
            rb     = q[0];
            e_norm = {2'b00, e1} - {2'b00, e2} + BIAS_W - 10'd1;
        end
        // A carry out of the fraction means the significand rolled over
        // to 2.0: fraction becomes zero and the exponent bumps by one.
        frac_rnd = {1'b0, frac} + {{MAN_W{1'b0}}, rb};
        e_rnd    = e_norm + (frac_rnd[MAN_W] ? 10'sd1 : 10'sd0);
    end

    // Exception mux, highest priority first.
    always_comb begin
        if (e2 == '0) begin
            y = {s, FP_INF_MAG};
        end else if (e1 == '0) begin
            y = 32'd0;
        end else if (e_rnd <= 10'sd0) begin
            y = 32'd0;
        end else if (e_rnd >= 10'sd255) begin
            y = {s, FP_INF_MAG};
        end else begin
            y = {s, e_rnd[7:0], frac_rnd[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/fdiv_iter.sv
// Iterative single-precision divider y = x1 / x2 using radix-2 restoring
// division on the 24-bit significands, one quotient bit per cycle.
// Zero-exponent inputs are treated as zero; results flush to zero.
// Optional: define FDIV_EARLY_OUT_EN to finish zero-operand divisions at
// the accept edge instead of running the full iteration.
module fdiv_iter #(
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);
    import fpu_pkg::*;

    localparam logic [4:0] CNT_LAST = 5'(FDIV_ITERS - 1);

    fdiv_state_t         state_reg;
    logic [4:0]          cnt_reg;
    logic [24:0]         r_reg;
    logic [23:0]         d_reg;
    logic [25:0]         q_reg;
    logic                s_reg;
    logic [EXP_W-1:0]    e1_reg;
    logic [EXP_W-1:0]    e2_reg;
    logic [31:0]         y_reg;
    logic                out_valid_reg;

    logic                q_bit;
    logic [24:0]         r_sub;
    logic [31:0]         y_round;

    // One restoring step: subtract the divisor when it fits.
    always_comb begin
        q_bit = (r_reg >= {1'b0, d_reg});
        r_sub = q_bit ? (r_reg - {1'b0, d_reg}) : r_reg;
    end

`ifdef FDIV_EARLY_OUT_EN
    logic        early_zero;
    logic [31:0] early_y;

    // Special result for a zero operand, available in the accept cycle.
    always_comb begin
        early_zero = (x1[30:23] == '0) || (x2[30:23] == '0);
        early_y    = (x2[30:23] == '0) ? {x1[31] ^ x2[31], FP_INF_MAG} : 32'd0;
    end
`endif

    fdiv_round #(
        .BIAS (BIAS)
    ) u_round (
        .q  (q_reg),
        .s  (s_reg),
        .e1 (e1_reg),
        .e2 (e2_reg),
        .y  (y_round)
    );

    // Control FSM plus remainder/quotient datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            r_reg         <= '0;
            d_reg         <= '0;
            q_reg         <= '0;
            s_reg         <= 1'b0;
            e1_reg        <= '0;
            e2_reg        <= '0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        s_reg   <= x1[31] ^ x2[31];
                        e1_reg  <= x1[30:23];
                        e2_reg  <= x2[30:23];
                        r_reg   <= {2'b01, x1[22:0]};
                        d_reg   <= {1'b1, x2[22:0]};
                        q_reg   <= '0;
                        cnt_reg <= '0;
`ifdef FDIV_EARLY_OUT_EN
                        if (early_zero) begin
                            y_reg         <= early_y;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            state_reg <= DIV;
                        end
`else
                        state_reg <= DIV;
`endif
                    end
                end
                DIV: begin
                    // Quotient bits enter at the LSB so the first one ends in q[25].
                    q_reg <= {q_reg[24:0], q_bit};
                    r_reg <= r_sub << 1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= ROUND;
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                ROUND: begin
                    y_reg         <= y_round;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // New operands are only taken while idle, never in the DONE handshake cycle.
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = out_valid_reg;
        y         = y_reg;
    end

endmodule
